wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that drives the single write port of the MIPS register file. It merges two result producers: the in-order ALU/load pipeline, which cannot stall and always wins, and the multi-cycle mul/div unit, whose results are buffered in a small FIFO and drained into idle write slots. A starvation guard asks the pipeline for a bubble when a buffered result has waited too long. Hazard-query ports report registers with pending buffered writes.

## Interface
Parameters:
- DEPTH, 4: mul/div result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8: wait cycles of the FIFO head before stall_req asserts (≥1).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_wb_valid  in  1  ALU/load result valid this cycle; never back-pressured.
- alu_wb_reg  in  5  ALU destination register.
- alu_wb_data  in  32  ALU result.
- md_valid  in  1  mul/div result offered.
- md_ready  out  1  FIFO can accept; equals !full.
- md_reg  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- wr_en  out  1  register-file write enable (registered).
- wr_reg  out  5  register-file write address (registered).
- wr_data  out  32  register-file write data (registered).
- stall_req  out  1  request for a pipeline bubble (registered).
- q_reg1, q_reg2  in  5  hazard-query register numbers.
- pend_hit1, pend_hit2  out  1  combinational; query matches a pending write.
- md_count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: md_valid && md_ready at a posedge writes {md_reg, md_data} at the tail. A push is never accepted when full, even in a cycle that also pops.
- Grant, evaluated each cycle:
  - alu_wb_valid=1: ALU granted. The FIFO holds, and the head wait counter increments if the FIFO is non-empty.
  - else FIFO non-empty: head granted and popped.
  - else: no grant, and wr_en=0 next cycle.
- Output stage: on the next posedge, the grantee is registered into wr_reg/wr_data with wr_en=1. A grant targeting register 0 is consumed (popped for FIFO), but wr_en=0 and wr_reg/wr_data hold their previous values.
- Starvation counter: reset to 0 on every pop and whenever the FIFO is empty. It increments when the head is blocked by the ALU and saturates at STARVE_LIMIT.
- stall_req is set on the posedge where the counter reaches STARVE_LIMIT and cleared on the posedge that pops the head. The pipeline must hold alu_wb_valid=0 while stall_req=1. If it does not, the ALU still wins and stall_req stays high.
- pend_hit: 1 if q_reg≠0 and it matches any valid FIFO entry or the output stage (wr_en=1 && wr_reg==q_reg). Query value 0 always returns 0.
- Pointers are log2(DEPTH) bits wrapping naturally. Occupancy is a separate counter: +1 on push only, −1 on pop only, unchanged on both.

## Timing
- Reset values (asynchronous): wr_en=0, wr_reg=0, wr_data=0, stall_req=0, md_count=0, pointers=0, starvation counter=0; md_ready=1 immediately.
- ALU latency: alu_wb_valid in cycle N gives wr_en=1 in cycle N+1.
- Mul/div latency, empty FIFO with ALU idle: accepted at edge k, so the head is visible in cycle k+1 and wr_en=1 in cycle k+2.
- Back-to-back: one write per cycle maximum; the FIFO drains one entry per idle ALU cycle.
- md_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop.
- Reset asserted mid-operation discards all FIFO contents and any in-flight output; no write issues after release until a new grant.

## Test plan
- Reset: hold rst_n=0 with random inputs -> wr_en=0, wr_reg=0, wr_data=0, stall_req=0, md_count=0, md_ready=1; release, ALU idle -> no writes.
- ALU priority: alu_wb_valid=1 (reg 5, 0x11111111) in the same cycle as md push (reg 7, 0x22222222) -> cycle+1 writes r5; cycle+2, with ALU idle, writes r7. pend_hit with q_reg1=7 is 1 from the cycle after the push through the output stage.
- Full/back-pressure: ALU busy every cycle; push 4 results (DEPTH=4) -> md_count=4, md_ready=0. A fifth md_valid is not accepted. Drop ALU -> 4 writes in FIFO order over 4 consecutive cycles.
- Starvation: one buffered entry, ALU valid continuously -> stall_req=1 after 8 blocked cycles. Bench drops ALU -> entry written next cycle, and stall_req clears on the pop edge.
- Register 0: md push and ALU write to r0 -> popped/consumed, wr_en stays 0, pend_hit for q_reg=0 is 0.
- Mid-operation reset: 3 entries buffered, assert rst_n=0 for 1 cycle -> md_count=0, no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register-file write port: the ALU/load pipeline always
// wins, mul/div results wait in a small FIFO and drain into idle write slots.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_wb_valid,
  input  logic [4:0]                 alu_wb_reg,
  input  logic [31:0]                alu_wb_data,
  input  logic                       md_valid,
  output logic                       md_ready,
  input  logic [4:0]                 md_reg,
  input  logic [31:0]                md_data,
  output logic                       wr_en,
  output logic [4:0]                 wr_reg,
  output logic [31:0]                wr_data,
  output logic                       stall_req,
  input  logic [4:0]                 q_reg1,
  input  logic [4:0]                 q_reg2,
  output logic                       pend_hit1,
  output logic                       pend_hit2,
  output logic [$clog2(DEPTH):0]     md_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       regMem_q  [DEPTH];
  logic [31:0]      dataMem_q [DEPTH];
  logic [DEPTH-1:0] slotVld_q, slotVld_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             wrEn_q, wrEn_d;
  logic [4:0]       wrReg_q, wrReg_d;
  logic [31:0]      wrData_q, wrData_d;

  logic empty, full, push, pop;
  logic hit1, hit2;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = md_valid && !full;
  assign pop   = !alu_wb_valid && !empty;

  // Next-state logic: FIFO bookkeeping, starvation guard and the output stage.
  always_comb begin
    count_d   = count_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    slotVld_d = slotVld_q;
    starve_d  = starve_q;
    stall_d   = stall_q;
    wrEn_d    = 1'b0;
    wrReg_d   = wrReg_q;
    wrData_d  = wrData_q;

    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    if (push) begin
      wrPtr_d            = wrPtr_q + PW'(1);
      slotVld_d[wrPtr_q] = 1'b1;
    end
    if (pop) begin
      rdPtr_d            = rdPtr_q + PW'(1);
      slotVld_d[rdPtr_q] = 1'b0;
    end

    if (empty || pop) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (alu_wb_valid && (starve_q != SW'(STARVE_LIMIT))) starve_d = starve_q + SW'(1);
      if (starve_d == SW'(STARVE_LIMIT)) stall_d = 1'b1;
    end

    // Writes to r0 are consumed but leave the previous address/data in place.
    if (alu_wb_valid) begin
      if (alu_wb_reg != 5'd0) begin
        wrEn_d   = 1'b1;
        wrReg_d  = alu_wb_reg;
        wrData_d = alu_wb_data;
      end
    end else if (pop) begin
      if (regMem_q[rdPtr_q] != 5'd0) begin
        wrEn_d   = 1'b1;
        wrReg_d  = regMem_q[rdPtr_q];
        wrData_d = dataMem_q[rdPtr_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotVld_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      wrEn_q    <= 1'b0;
      wrReg_q   <= '0;
      wrData_q  <= '0;
    end else begin
      slotVld_q <= slotVld_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      wrEn_q    <= wrEn_d;
      wrReg_q   <= wrReg_d;
      wrData_q  <= wrData_d;
    end
  end

  // Payload storage needs no reset; slotVld_q qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      regMem_q[wrPtr_q]  <= md_reg;
      dataMem_q[wrPtr_q] <= md_data;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotVld_q[i] && (regMem_q[i] == q_reg1)) hit1 = 1'b1;
      if (slotVld_q[i] && (regMem_q[i] == q_reg2)) hit2 = 1'b1;
    end
    if (wrEn_q && (wrReg_q == q_reg1)) hit1 = 1'b1;
    if (wrEn_q && (wrReg_q == q_reg2)) hit2 = 1'b1;
  end

  assign pend_hit1 = (q_reg1 != 5'd0) && hit1;
  assign pend_hit2 = (q_reg2 != 5'd0) && hit2;
  assign md_ready  = !full;
  assign md_count  = count_q;
  assign wr_en     = wrEn_q;
  assign wr_reg    = wrReg_q;
  assign wr_data   = wrData_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected writes, a negedge monitor
// pops and compares every register-file write the DUT issues.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_reg;
  logic [31:0] alu_wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        stall_req;
  logic [4:0]  q_reg1;
  logic [4:0]  q_reg2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [2:0]  md_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] expQ [$];

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .stall_req(stall_req),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .md_count(md_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; expected writes are queued in the order they must appear.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input bit expAlu, input bit expMd);
    alu_wb_valid = av; alu_wb_reg = ar; alu_wb_data = ad;
    md_valid = mv; md_reg = mr; md_data = md;
    if (expAlu) expQ.push_back({ar, ad});
    if (expMd) expQ.push_back({mr, md});
    @(posedge clk);
    #1;
    alu_wb_valid = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      logic [36:0] e;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got r%0d=0x%0h, expected no write", wr_reg, wr_data);
      end else begin
        e = expQ.pop_front();
        if ({wr_reg, wr_data} !== e) begin
          errors++;
          $display("[TB] FAIL write_order: got r%0d=0x%0h, expected r%0d=0x%0h",
                   wr_reg, wr_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    q_reg1 = 5'd0; q_reg2 = 5'd0;
    for (int i = 0; i < 4; i++) begin
      alu_wb_valid = 1'($urandom); alu_wb_reg = 5'($urandom); alu_wb_data = $urandom;
      md_valid = 1'($urandom); md_reg = 5'($urandom); md_data = $urandom;
      @(negedge clk);
    end
    checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset_wr_reg", 32'(wr_reg), 32'd0);
    checkOutput("reset_wr_data", wr_data, 32'd0);
    checkOutput("reset_stall", 32'(stall_req), 32'd0);
    checkOutput("reset_count", 32'(md_count), 32'd0);
    checkOutput("reset_md_ready", 32'(md_ready), 32'd1);
    alu_wb_valid = 1'b0; md_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // ALU priority over a simultaneous mul/div push
    q_reg1 = 5'd7; q_reg2 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b1, 1'b1);
    checkOutput("prio_alu_wr_en", 32'(wr_en), 32'd1);
    checkOutput("prio_alu_wr_reg", 32'(wr_reg), 32'd5);
    checkOutput("prio_pend_fifo", 32'(pend_hit1), 32'd1);
    checkOutput("prio_pend_outstage", 32'(pend_hit2), 32'd1);
    checkOutput("prio_count", 32'(md_count), 32'd1);
    idle(1);
    checkOutput("prio_md_wr_reg", 32'(wr_reg), 32'd7);
    checkOutput("prio_pend_md_out", 32'(pend_hit1), 32'd1);
    checkOutput("prio_pend_r5_gone", 32'(pend_hit2), 32'd0);
    idle(1);
    checkOutput("prio_pend_cleared", 32'(pend_hit1), 32'd0);
    checkOutput("prio_wr_en_off", 32'(wr_en), 32'd0);

    // Fill the FIFO behind a busy ALU (writing r0), then drain
    q_reg1 = 5'd11; q_reg2 = 5'd12;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
    checkOutput("full_count", 32'(md_count), 32'd4);
    checkOutput("full_md_ready", 32'(md_ready), 32'd0);
    checkOutput("full_pend_r11", 32'(pend_hit1), 32'd1);
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd12, 32'hDEAD0012, 1'b0, 1'b0);
    checkOutput("full_reject_count", 32'(md_count), 32'd4);
    checkOutput("full_reject_pend", 32'(pend_hit2), 32'd0);
    idle(1);
    checkOutput("drain0_reg", 32'(wr_reg), 32'd8);
    checkOutput("drain_md_ready", 32'(md_ready), 32'd1);
    checkOutput("drain_count", 32'(md_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      idle(1);
      checkOutput("drain_wr_en", 32'(wr_en), 32'd1);
      checkOutput("drain_reg", 32'(wr_reg), 32'(8 + i));
    end
    checkOutput("drain_empty", 32'(md_count), 32'd0);
    idle(1);

    // Starvation guard
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd20, 32'h0000_0020, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("starve_7_no_stall", 32'(stall_req), 32'd0);
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("starve_8_stall", 32'(stall_req), 32'd1);
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("starve_ignored_stall", 32'(stall_req), 32'd1);
    idle(1);
    checkOutput("starve_pop_reg", 32'(wr_reg), 32'd20);
    checkOutput("starve_pop_clear", 32'(stall_req), 32'd0);
    idle(1);

    // Register 0 grants are consumed without a write
    q_reg1 = 5'd0; q_reg2 = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd0, 32'hBAD0_0000, 1'b1, 5'd0, 32'hBAD0_0001, 1'b0, 1'b0);
    checkOutput("r0_alu_wr_en", 32'(wr_en), 32'd0);
    checkOutput("r0_hold_reg", 32'(wr_reg), 32'd3);
    checkOutput("r0_hold_data", wr_data, 32'h3333_3333);
    checkOutput("r0_pend_q0", 32'(pend_hit1), 32'd0);
    checkOutput("r0_count", 32'(md_count), 32'd1);
    idle(1);
    checkOutput("r0_md_wr_en", 32'(wr_en), 32'd0);
    checkOutput("r0_popped", 32'(md_count), 32'd0);

    // Mid-operation reset discards buffered entries and the in-flight write
    q_reg1 = 5'd24;
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd24, 32'h24, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd25, 32'h25, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd2, 32'h0202_0202, 1'b1, 5'd26, 32'h26, 1'b0, 1'b0);
    checkOutput("mid_count3", 32'(md_count), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_count", 32'(md_count), 32'd0);
    checkOutput("mid_rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("mid_rst_wr_reg", 32'(wr_reg), 32'd0);
    checkOutput("mid_rst_pend", 32'(pend_hit1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(4);
    checkOutput("mid_after_wr_en", 32'(wr_en), 32'd0);
    applyStimulus(1'b1, 5'd1, 32'h0101_0101, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("post_rst_alu_reg", 32'(wr_reg), 32'd1);
    idle(2);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
